serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder. It drives one Full_Adder stage one bit per cycle, LSB first.
//   It latches two operands and a carry-in on Start_In, then iterates WIDTH cycles.
//   It returns Sum_Out/Carry_Out with a one-cycle Done_Out pulse.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder.sv | 16 +
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Imported by serial_adder and its one-bit slice.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sa_state_t;

  localparam int SA_MIN_WIDTH = 2;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial bit slice.
// Purely combinational.
import serial_adder_pkg::*;

module serial_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder slice.
// Optional SERIAL_ADDER_OVERFLOW_EN adds a registered Overflow_Out.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start_In,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  input  logic             Carry_In,
  output logic             Busy_Out,
  output logic             Done_Out,
  output logic [WIDTH-1:0] Sum_Out,
  output logic             Carry_Out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow_Out
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < SA_MIN_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH below SA_MIN_WIDTH");
  end

  sa_state_t        state;
  sa_state_t        state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_q;
  logic             fa_sum;
  logic             fa_co;
  logic             last;

  serial_adder_full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_co)
  );

  assign last     = (state == SHIFT) && (count == LAST);
  assign res_nxt  = (res_sr >> 1)
                  | {fa_sum, {(WIDTH-1){1'b0}}};
  assign Busy_Out = (state != IDLE);
  assign Done_Out = (state == DONE);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start_In) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count     <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry_q   <= 1'b0;
      Sum_Out   <= '0;
      Carry_Out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start_In) begin
          a_sr    <= Data_A_In;
          b_sr    <= Data_B_In;
          carry_q <= Carry_In;
          count   <= '0;
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_nxt;
          carry_q <= fa_co;
          count   <= last ? '0 : count + CW'(1);
          // final bit lands in the outputs on DONE entry
          if (last) begin
            Sum_Out   <= res_nxt;
            Carry_Out <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // carry_q holds the carry into the MSB during the last shift
  always_ff @(posedge Clock) begin
    if (Reset)     Overflow_Out <= 1'b0;
    else if (last) Overflow_Out <= carry_q ^ fa_co;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8 and 13.
// Random ops are checked against an integer-arithmetic model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_x   [2];
  logic [31:0] a_x    [2];
  logic [31:0] b_x    [2];
  logic        c_x    [2];
  logic        busy_x [2];
  logic        done_x [2];
  logic        co_x   [2];
  logic        ovf_x  [2];
  logic [31:0] sum_x  [2];
  logic [7:0]  s8;
  logic [12:0] s13;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign sum_x[0] = {24'd0, s8};
  assign sum_x[1] = {19'd0, s13};

  serial_adder #(.WIDTH(8)) u_dut8 (
    .Clock     (clk),
    .Reset     (rst),
    .Start_In  (st_x[0]),
    .Data_A_In (a_x[0][7:0]),
    .Data_B_In (b_x[0][7:0]),
    .Carry_In  (c_x[0]),
    .Busy_Out  (busy_x[0]),
    .Done_Out  (done_x[0]),
    .Sum_Out   (s8),
    .Carry_Out (co_x[0])
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .Overflow_Out (ovf_x[0])
`endif
  );

  serial_adder #(.WIDTH(13)) u_dut13 (
    .Clock     (clk),
    .Reset     (rst),
    .Start_In  (st_x[1]),
    .Data_A_In (a_x[1][12:0]),
    .Data_B_In (b_x[1][12:0]),
    .Carry_In  (c_x[1]),
    .Busy_Out  (busy_x[1]),
    .Done_Out  (done_x[1]),
    .Sum_Out   (s13),
    .Carry_Out (co_x[1])
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .Overflow_Out (ovf_x[1])
`endif
  );

`ifndef SERIAL_ADDER_OVERFLOW_EN
  assign ovf_x[0] = 1'b0;
  assign ovf_x[1] = 1'b0;
`endif

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 13;
  endfunction

  function automatic logic [63:0] add_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic c);
    return 64'(a) + 64'(b) + 64'(c);
  endfunction

  function automatic logic ovf_ref(input int w,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic c);
    longint lim = longint'(1) << (w - 1);
    longint sa  = longint'(a);
    longint sb  = longint'(b);
    longint r;
    if (sa >= lim) sa = sa - 2 * lim;
    if (sb >= lim) sb = sb - 2 * lim;
    r = sa + sb + longint'(c);
    return (r >= lim) || (r < -lim);
  endfunction

  // Start one op; optional noise re-pulses Start mid-op and during Done.
  task automatic run_op(input int i,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic c,
                        input bit noise,
                        output int lat,
                        output int busy_n,
                        output int pulses);
    int w = wid(i);
    @(negedge clk);
    a_x[i] = a; b_x[i] = b; c_x[i] = c; st_x[i] = 1'b1;
    @(negedge clk);
    st_x[i] = 1'b0;
    lat = -1; busy_n = 0; pulses = 0;
    for (int j = 0; j < w + 4; j++) begin
      if (busy_x[i]) busy_n++;
      if (done_x[i]) begin
        pulses++;
        if (lat < 0) lat = j + 1;
      end
      if (noise && (j == 2 || done_x[i])) begin
        st_x[i] = 1'b1; a_x[i] = ~a; b_x[i] = a; c_x[i] = ~c;
      end else begin
        st_x[i] = 1'b0;
      end
      @(negedge clk);
    end
    st_x[i] = 1'b0;
  endtask

  task automatic directed(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic c,
                          input logic [31:0] e_sum,
                          input logic e_co);
    int lat, bn, pl;
    run_op(0, a, b, c, 1'b0, lat, bn, pl);
    check({tag, "_pulses"}, 64'(pl), 64'd1);
    check({tag, "_sum"}, 64'(sum_x[0]), 64'(e_sum));
    check({tag, "_carry"}, 64'(co_x[0]), 64'(e_co));
  endtask

  task automatic rand_run(input int i, input int n);
    int w = wid(i);
    logic [31:0] m = (32'd1 << w) - 32'd1;
    int seen = 0;
    int cyc  = 0;
    int last = -1;
    logic [63:0] r;
    logic [31:0] hold = '0;
    a_x[i] = $urandom & m;
    b_x[i] = $urandom & m;
    c_x[i] = 1'($urandom);
    st_x[i] = 1'b1;
    while (seen < n && cyc < n * (w + 2) + 100) begin
      @(negedge clk);
      cyc++;
      if (done_x[i]) begin
        r = add_ref(a_x[i], b_x[i], c_x[i]);
        check("rnd_sum", 64'(sum_x[i]), r & 64'(m));
        check("rnd_carry", 64'(co_x[i]), (r >> w) & 64'd1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("rnd_ovf", 64'(ovf_x[i]),
              64'(ovf_ref(w, a_x[i], b_x[i], c_x[i])));
`endif
        if (last >= 0) check("rnd_gap", 64'(cyc - last), 64'(w + 2));
        last = cyc;
        hold = 32'(r) & m;
        seen++;
        a_x[i] = $urandom & m;
        b_x[i] = $urandom & m;
        c_x[i] = 1'($urandom);
      end else if (seen > 0) begin
        check("rnd_hold", 64'(sum_x[i]), 64'(hold));
      end
    end
    st_x[i] = 1'b0;
    check("rnd_count", 64'(seen), 64'(n));
  endtask

  initial begin
    int lat, bn, pl;
    for (int i = 0; i < 2; i++) begin
      st_x[i] = 1'b0; a_x[i] = '0; b_x[i] = '0; c_x[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_x[0]), 64'd0);
    check("rst_done", 64'(done_x[0]), 64'd0);
    check("rst_sum", 64'(sum_x[0]), 64'd0);
    check("rst_carry", 64'(co_x[0]), 64'd0);
    rst = 1'b0;

    run_op(0, 32'h35, 32'h4A, 1'b0, 1'b0, lat, bn, pl);
    check("t1_lat", 64'(lat), 64'd9);
    check("t1_busy", 64'(bn), 64'd9);
    check("t1_pulses", 64'(pl), 64'd1);
    check("t1_sum", 64'(sum_x[0]), 64'h7F);
    check("t1_carry", 64'(co_x[0]), 64'd0);

    directed("t2a", 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1);
    directed("t2b", 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1);

    run_op(0, 32'h12, 32'h34, 1'b1, 1'b1, lat, bn, pl);
    check("t3_pulses", 64'(pl), 64'd1);
    check("t3_sum", 64'(sum_x[0]), 64'h47);
    check("t3_carry", 64'(co_x[0]), 64'd0);

    @(negedge clk);
    a_x[0] = 32'h55; b_x[0] = 32'h66; c_x[0] = 1'b0; st_x[0] = 1'b1;
    @(negedge clk);
    st_x[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", 64'(busy_x[0]), 64'd0);
    check("t4_done", 64'(done_x[0]), 64'd0);
    check("t4_sum", 64'(sum_x[0]), 64'd0);
    check("t4_carry", 64'(co_x[0]), 64'd0);
    check("t4_ovf", 64'(ovf_x[0]), 64'd0);
    pl = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_x[0]) pl++;
    end
    check("t4_nodone", 64'(pl), 64'd0);
    directed("t4_fresh", 32'h10, 32'h20, 1'b0, 32'h30, 1'b0);

`ifdef SERIAL_ADDER_OVERFLOW_EN
    directed("t5a", 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0);
    check("t5a_ovf", 64'(ovf_x[0]), 64'd1);
    directed("t5b", 32'h80, 32'h80, 1'b0, 32'h00, 1'b1);
    check("t5b_ovf", 64'(ovf_x[0]), 64'd1);
    directed("t5c", 32'h05, 32'h03, 1'b0, 32'h08, 1'b0);
    check("t5c_ovf", 64'(ovf_x[0]), 64'd0);
`endif

    fork
      rand_run(0, 200);
      rand_run(1, 200);
    join
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
